// File: rtl/program_counter_pkg.sv
// +--------------------------------------------------------------------------+
// | program_counter_pkg : shared address width and PC load-mode encoding      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

package program_counter_pkg;

  localparam int unsigned XLEN = 32;

  // Meaning of d_r_i when a load is requested
  typedef enum logic {
    PC_LOAD_DIRECT   = 1'b0,
    PC_LOAD_RELATIVE = 1'b1
  } pc_load_mode_e;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/program_counter_if.sv
// +--------------------------------------------------------------------------+
// | program_counter_if : control/load inputs and PC outputs of the fetch PC   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

interface program_counter_if;
  import program_counter_pkg::*;

  logic            en_i;
  logic            ld_ct_i;
  logic            d_r_i;
  logic [XLEN-1:0] ld_i;
  logic [XLEN-1:0] pc_o;
  logic            is_aligned_o;

  // Branch/jump resolution side
  modport master (
    output en_i, ld_ct_i, d_r_i, ld_i,
    input  pc_o, is_aligned_o
  );

  // The program counter itself
  modport slave (
    input  en_i, ld_ct_i, d_r_i, ld_i,
    output pc_o, is_aligned_o
  );

endinterface

`default_nettype wire

// File: rtl/program_counter.sv
// +--------------------------------------------------------------------------+
// | program_counter : fetch-stage PC with stride increment and abs/rel loads  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module program_counter
  import program_counter_pkg::*;
#(
  parameter int unsigned     INC_BY    = 4,
  parameter logic [XLEN-1:0] RESET_VAL = 32'h0000_0000
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  program_counter_if.slave   bus
);

  localparam logic [XLEN-1:0] C_STRIDE     = XLEN'(INC_BY);
  localparam logic [XLEN-1:0] C_ALIGN_MASK = XLEN'(INC_BY - 1);

  generate
    if (!is_pow2(INC_BY)) begin : g_bad_inc_by
      $error("program_counter: INC_BY must be a power of two");
    end
    if ((RESET_VAL & C_ALIGN_MASK) != '0) begin : g_bad_reset_val
      $error("program_counter: RESET_VAL must be aligned to INC_BY");
    end
  endgenerate

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Arithmetic wraps modulo 2^XLEN; a negative offset is just two's complement
  always_comb begin
    pc_d = pc_q;
    if (bus.en_i) begin
      if (bus.ld_ct_i) begin
        if (pc_load_mode_e'(bus.d_r_i) == PC_LOAD_RELATIVE) begin
          pc_d = pc_q + bus.ld_i;
        end else begin
          pc_d = bus.ld_i;
        end
      end else begin
        pc_d = pc_q + C_STRIDE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.pc_o         = pc_q;
  assign bus.is_aligned_o = ((pc_q & C_ALIGN_MASK) == '0);

endmodule

`default_nettype wire

// File: tb/tb_program_counter.sv
// +--------------------------------------------------------------------------+
// | tb_program_counter : directed self-checking bench (INC_BY = 4 and 2)      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_program_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  program_counter_if bus4 ();
  program_counter_if bus2 ();

  program_counter #(.INC_BY(4), .RESET_VAL(32'h0000_0000)) u_dut4 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus4)
  );

  program_counter #(.INC_BY(2), .RESET_VAL(32'h0000_0000)) u_dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [31:0] pc, input logic al);
    check({tag, ".pc"}, bus4.pc_o, pc);
    check({tag, ".al"}, {31'd0, bus4.is_aligned_o}, {31'd0, al});
  endtask

  initial begin
    bus4.en_i = 1'b1; bus4.ld_ct_i = 1'b1; bus4.d_r_i = 1'b0; bus4.ld_i = 32'h40;
    bus2.en_i = 1'b0; bus2.ld_ct_i = 1'b0; bus2.d_r_i = 1'b0; bus2.ld_i = 32'h0;

    // Reset held two cycles with a pending load
    step(); check4("rst0", 32'h0, 1'b1);
    step(); check4("rst1", 32'h0, 1'b1);
    check("rst_dut2", bus2.pc_o, 32'h0);

    // Increment after release
    rst = 1'b0; bus4.ld_ct_i = 1'b0;
    step(); check4("inc4", 32'd4, 1'b1);
    step(); check4("inc8", 32'd8, 1'b1);
    step(); check4("inc12", 32'd12, 1'b1);

    // Stall three cycles
    bus4.en_i = 1'b0;
    step(); check4("stall0", 32'd12, 1'b1);
    step(); check4("stall1", 32'd12, 1'b1);
    step(); check4("stall2", 32'd12, 1'b1);

    // Disabled load is ignored
    bus4.ld_ct_i = 1'b1; bus4.ld_i = 32'h99;
    step(); check4("en0_ld", 32'd12, 1'b1);

    // Misaligned direct load, then increment
    bus4.en_i = 1'b1; bus4.d_r_i = 1'b0; bus4.ld_i = 32'h3;
    step(); check4("ld_abs3", 32'h3, 1'b0);
    bus4.ld_ct_i = 1'b0;
    step(); check4("inc7", 32'h7, 1'b0);

    // Relative loads, held for accumulation
    bus4.ld_ct_i = 1'b1; bus4.d_r_i = 1'b0; bus4.ld_i = 32'h100;
    step(); check4("ld_abs100", 32'h100, 1'b1);
    bus4.d_r_i = 1'b1; bus4.ld_i = 32'h1;
    step(); check4("rel_p1", 32'h101, 1'b0);
    step(); check4("rel_p1_held", 32'h102, 1'b0);
    bus4.d_r_i = 1'b0; bus4.ld_i = 32'h100;
    step(); check4("ld_abs100b", 32'h100, 1'b1);
    bus4.d_r_i = 1'b1; bus4.ld_i = 32'hFFFF_FFF0;
    step(); check4("rel_m16", 32'hF0, 1'b1);

    // Wrap-around on increment and on relative add
    bus4.d_r_i = 1'b0; bus4.ld_i = 32'hFFFF_FFFC;
    step(); check4("ld_top", 32'hFFFF_FFFC, 1'b1);
    bus4.ld_ct_i = 1'b0;
    step(); check4("wrap_inc", 32'h0, 1'b1);
    bus4.ld_ct_i = 1'b1;
    step(); check4("ld_top2", 32'hFFFF_FFFC, 1'b1);
    bus4.d_r_i = 1'b1; bus4.ld_i = 32'h8;
    step(); check4("wrap_rel", 32'h4, 1'b1);

    // Reset beats a simultaneous load
    rst = 1'b1; bus4.d_r_i = 1'b0; bus4.ld_i = 32'h40;
    step(); check4("rst_prio", 32'h0, 1'b1);
    rst = 1'b0; bus4.en_i = 1'b0;

    // Stride-2 instance alignment
    bus2.en_i = 1'b1; bus2.ld_ct_i = 1'b1; bus2.d_r_i = 1'b0; bus2.ld_i = 32'd6;
    step();
    check("inc2_pc6", bus2.pc_o, 32'd6);
    check("inc2_al6", {31'd0, bus2.is_aligned_o}, 32'd1);
    bus2.ld_i = 32'd5;
    step();
    check("inc2_pc5", bus2.pc_o, 32'd5);
    check("inc2_al5", {31'd0, bus2.is_aligned_o}, 32'd0);
    bus2.ld_ct_i = 1'b0;
    step();
    check("inc2_pc7", bus2.pc_o, 32'd7);
    check("dut4_hold", bus4.pc_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
